// File: rtl/text_glyph_streamer_pkg.sv
// Shared types and defaults for the text glyph streamer: FSM state encoding,
// sprite-sheet geometry defaults and a width helper.
package text_glyph_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_t;

  localparam int DEF_MAX_CHARS      = 8;
  localparam int DEF_GLYPH_H        = 8;
  localparam int DEF_GLYPH_W        = 8;
  localparam int DEF_SHEET_W        = 160;
  localparam int DEF_FONT_BASE      = 10272;
  localparam int DEF_GLYPHS_PER_ROW = 8;
  localparam int DEF_NUM_GLYPHS     = 36;

  localparam int ADDR_W = 20;
  localparam int CODE_W = 6;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/text_glyph_streamer_if.sv
// Output beat stream of the glyph streamer: one glyph-row address per beat,
// tagged with its character index and row, under a valid/ready handshake.
interface text_glyph_streamer_if
  import text_glyph_streamer_pkg::*;
#(
  parameter int MAX_CHARS = DEF_MAX_CHARS,
  parameter int GLYPH_H   = DEF_GLYPH_H
);

  localparam int IDX_W = idxWidth(MAX_CHARS);
  localparam int ROW_W = idxWidth(GLYPH_H);

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [IDX_W-1:0]  out_char_idx;
  logic [ROW_W-1:0]  out_row;

  modport master (
    output out_valid,
    output out_addr,
    output out_char_idx,
    output out_row,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_char_idx,
    input  out_row,
    output out_ready
  );

endinterface

// File: rtl/text_glyph_streamer_glyph_base_calc.sv
// Maps a character code to the sheet address of its glyph's top-left pixel;
// codes outside the font fall back to glyph 0 and raise o_bad.
module glyph_base_calc
  import text_glyph_streamer_pkg::*;
#(
  parameter int FONT_BASE      = DEF_FONT_BASE,
  parameter int SHEET_W        = DEF_SHEET_W,
  parameter int GLYPH_H        = DEF_GLYPH_H,
  parameter int GLYPH_W        = DEF_GLYPH_W,
  parameter int GLYPHS_PER_ROW = DEF_GLYPHS_PER_ROW,
  parameter int NUM_GLYPHS     = DEF_NUM_GLYPHS
) (
  input  logic [CODE_W-1:0] i_code,
  output logic [ADDR_W-1:0] o_base,
  output logic              o_bad
);

  localparam logic [ADDR_W-1:0] BASE        = ADDR_W'(FONT_BASE);
  localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(GLYPH_H * SHEET_W);
  localparam logic [ADDR_W-1:0] COL_STRIDE  = ADDR_W'(GLYPH_W);
  localparam logic [ADDR_W-1:0] PER_ROW     = ADDR_W'(GLYPHS_PER_ROW);
  localparam logic [ADDR_W-1:0] GLYPH_LIMIT = ADDR_W'(NUM_GLYPHS);

  logic [ADDR_W-1:0] w_codeWide;
  logic [ADDR_W-1:0] w_glyph;

  always_comb begin
    w_codeWide = ADDR_W'(i_code);
    o_bad      = (w_codeWide >= GLYPH_LIMIT);
    w_glyph    = o_bad ? '0 : w_codeWide;
    o_base     = BASE + (w_glyph / PER_ROW) * ROW_STRIDE + (w_glyph % PER_ROW) * COL_STRIDE;
  end

endmodule

// File: rtl/text_glyph_streamer.sv
// Streams the sheet addresses of every glyph row of a buffered string,
// in char-major or row-major order, one registered beat per accepted handshake.
module text_glyph_streamer
  import text_glyph_streamer_pkg::*;
#(
  parameter int MAX_CHARS      = DEF_MAX_CHARS,
  parameter int GLYPH_H        = DEF_GLYPH_H,
  parameter int SHEET_W        = DEF_SHEET_W,
  parameter int FONT_BASE      = DEF_FONT_BASE,
  parameter int GLYPHS_PER_ROW = DEF_GLYPHS_PER_ROW,
  parameter int GLYPH_W        = DEF_GLYPH_W,
  parameter int NUM_GLYPHS     = DEF_NUM_GLYPHS,
  localparam int IDX_W         = idxWidth(MAX_CHARS),
  localparam int LEN_W         = IDX_W + 1,
  localparam int ROW_W         = idxWidth(GLYPH_H)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_wr_en,
  input  logic [IDX_W-1:0]        i_wr_idx,
  input  logic [CODE_W-1:0]       i_wr_char,
  input  logic [LEN_W-1:0]        i_num_chars,
  input  logic                    i_mode,
  input  logic                    i_start,
  text_glyph_streamer_if.master   o_stream,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_bad_code
);

  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_CHARS);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(GLYPH_H - 1);
  localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(SHEET_W);

  state_t            r_state;
  logic [CODE_W-1:0] r_buf [MAX_CHARS];
  logic [LEN_W-1:0]  r_len;
  logic              r_mode;

  logic [LEN_W-1:0]  w_startLen;
  logic              w_lastChar;
  logic              w_lastRow;
  logic              w_lastBeat;
  logic [IDX_W-1:0]  w_nextChar;
  logic [ROW_W-1:0]  w_nextRow;
  logic [IDX_W-1:0]  w_rdChar;
  logic [ROW_W-1:0]  w_rdRow;
  logic              w_wrOk;
  logic [CODE_W-1:0] w_code;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_addr;
  logic              w_bad;

  // The outputs hold the current beat position; the next one is derived from it.
  // In IDLE the lookup targets beat 0, with a same-cycle write forwarded into it.
  always_comb begin
    w_startLen = (i_num_chars > MAX_LEN) ? MAX_LEN : i_num_chars;
    w_lastChar = ({1'b0, o_stream.out_char_idx} == (r_len - LEN_ONE));
    w_lastRow  = (o_stream.out_row == ROW_LAST);
    w_lastBeat = w_lastChar && w_lastRow;
    w_nextChar = o_stream.out_char_idx;
    w_nextRow  = o_stream.out_row;
    if (!r_mode) begin
      if (w_lastRow) begin
        w_nextRow  = '0;
        w_nextChar = o_stream.out_char_idx + 1'b1;
      end else begin
        w_nextRow  = o_stream.out_row + 1'b1;
      end
    end else begin
      if (w_lastChar) begin
        w_nextChar = '0;
        w_nextRow  = o_stream.out_row + 1'b1;
      end else begin
        w_nextChar = o_stream.out_char_idx + 1'b1;
      end
    end
    w_rdChar = (r_state == ST_IDLE) ? '0 : w_nextChar;
    w_rdRow  = (r_state == ST_IDLE) ? '0 : w_nextRow;
    w_wrOk   = i_wr_en && (r_state != ST_STREAM);
    w_code   = (w_wrOk && (i_wr_idx == w_rdChar)) ? i_wr_char : r_buf[w_rdChar];
    w_addr   = w_base + ADDR_W'(w_rdRow) * ROW_PITCH;
  end

  glyph_base_calc #(
    .FONT_BASE      (FONT_BASE),
    .SHEET_W        (SHEET_W),
    .GLYPH_H        (GLYPH_H),
    .GLYPH_W        (GLYPH_W),
    .GLYPHS_PER_ROW (GLYPHS_PER_ROW),
    .NUM_GLYPHS     (NUM_GLYPHS)
  ) u_glyphBase (
    .i_code (w_code),
    .o_base (w_base),
    .o_bad  (w_bad)
  );

  // String storage survives reset so an aborted stream can simply be restarted.
  always_ff @(posedge i_clk) begin
    if (w_wrOk) begin
      r_buf[i_wr_idx] <= i_wr_char;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state               <= ST_IDLE;
      r_len                 <= '0;
      r_mode                <= 1'b0;
      o_stream.out_valid    <= 1'b0;
      o_stream.out_addr     <= '0;
      o_stream.out_char_idx <= '0;
      o_stream.out_row      <= '0;
      o_busy                <= 1'b0;
      o_done                <= 1'b0;
      o_bad_code            <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_len                 <= w_startLen;
            r_mode                <= i_mode;
            o_stream.out_char_idx <= '0;
            o_stream.out_row      <= '0;
            if (w_startLen == '0) begin
              r_state    <= ST_DONE;
              o_done     <= 1'b1;
              o_bad_code <= 1'b0;
            end else begin
              r_state            <= ST_STREAM;
              o_stream.out_valid <= 1'b1;
              o_stream.out_addr  <= w_addr;
              o_busy             <= 1'b1;
              o_bad_code         <= w_bad;
            end
          end
        end
        ST_STREAM: begin
          if (o_stream.out_valid && o_stream.out_ready) begin
            if (w_lastBeat) begin
              r_state            <= ST_DONE;
              o_stream.out_valid <= 1'b0;
              o_busy             <= 1'b0;
              o_done             <= 1'b1;
            end else begin
              o_stream.out_char_idx <= w_nextChar;
              o_stream.out_row      <= w_nextRow;
              o_stream.out_addr     <= w_addr;
              o_bad_code            <= o_bad_code | w_bad;
            end
          end
        end
        ST_DONE: begin
          o_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_glyph_streamer.sv
// Randomized self-checking bench for text_glyph_streamer: each stream is compared
// beat by beat against an address list built from the sprite-sheet arithmetic.
module tb_text_glyph_streamer;
  import text_glyph_streamer_pkg::*;

  localparam int MAXC = 8;
  localparam int GH   = 8;
  localparam int SW   = 160;
  localparam int FB   = 10272;
  localparam int GPR  = 8;
  localparam int GW   = 8;
  localparam int NG   = 36;

  logic       clk = 1'b0;
  logic       reset;
  logic       wrEn;
  logic [2:0] wrIdx;
  logic [5:0] wrChar;
  logic [3:0] numChars;
  logic       modeSel;
  logic       start;
  logic       busy;
  logic       done;
  logic       badCode;

  int vectorCount = 0;
  int missCount   = 0;
  int modelBuf [MAXC];
  int obsAddr [$];

  text_glyph_streamer_if #(.MAX_CHARS(MAXC), .GLYPH_H(GH)) outIf ();

  text_glyph_streamer #(
    .MAX_CHARS      (MAXC),
    .GLYPH_H        (GH),
    .SHEET_W        (SW),
    .FONT_BASE      (FB),
    .GLYPHS_PER_ROW (GPR),
    .GLYPH_W        (GW),
    .NUM_GLYPHS     (NG)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_wr_en     (wrEn),
    .i_wr_idx    (wrIdx),
    .i_wr_char   (wrChar),
    .i_num_chars (numChars),
    .i_mode      (modeSel),
    .i_start     (start),
    .o_stream    (outIf),
    .o_busy      (busy),
    .o_done      (done),
    .o_bad_code  (badCode)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Sheet address of a glyph row, straight from the font layout.
  function automatic int glyphAddr(input int code, input int row);
    int g;
    g = (code >= NG) ? 0 : code;
    return FB + (g / GPR) * GH * SW + (g % GPR) * GW + row * SW;
  endfunction

  task automatic writeChar(input int idx, input int code);
    @(negedge clk);
    wrEn   = 1'b1;
    wrIdx  = 3'(idx);
    wrChar = 6'(code);
    modelBuf[idx] = code;
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  // Starts one stream and follows it to completion (or to a reset at beat abortAt).
  task automatic applyStimulus(input int n, input bit mode, input int stallPct,
                               input int abortAt, input bit coWrite);
    int len;
    int total;
    int beat;
    int cycles;
    int cwIdx;
    int cwCode;
    bit expBad;
    int expA [$];
    int expC [$];
    int expR [$];

    len    = (n > MAXC) ? MAXC : n;
    cwIdx  = $urandom_range(0, MAXC - 1);
    cwCode = $urandom_range(0, 39);
    if (coWrite) modelBuf[cwIdx] = cwCode;

    if (!mode) begin
      for (int c = 0; c < len; c++)
        for (int r = 0; r < GH; r++) begin
          expA.push_back(glyphAddr(modelBuf[c], r)); expC.push_back(c); expR.push_back(r);
        end
    end else begin
      for (int r = 0; r < GH; r++)
        for (int c = 0; c < len; c++) begin
          expA.push_back(glyphAddr(modelBuf[c], r)); expC.push_back(c); expR.push_back(r);
        end
    end
    expBad = 1'b0;
    for (int c = 0; c < len; c++) if (modelBuf[c] >= NG) expBad = 1'b1;
    total = expA.size();
    obsAddr.delete();

    @(negedge clk);
    numChars = 4'(n);
    modeSel  = mode;
    start    = 1'b1;
    outIf.out_ready = 1'b1;
    if (coWrite) begin
      wrEn   = 1'b1;
      wrIdx  = 3'(cwIdx);
      wrChar = 6'(cwCode);
    end
    @(negedge clk);
    start = 1'b0;
    wrEn  = 1'b0;

    if (len == 0) begin
      checkOutput("n0_valid", outIf.out_valid, 0);
      checkOutput("n0_done", done, 1);
      checkOutput("n0_busy", busy, 0);
      checkOutput("n0_bad", badCode, 0);
      @(negedge clk);
      checkOutput("n0_done_pulse", done, 0);
      return;
    end

    beat   = 0;
    cycles = 0;
    while (beat < total) begin
      if (abortAt >= 0 && beat == abortAt) begin
        reset = 1'b1; start = 1'b0; wrEn = 1'b0; outIf.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_valid", outIf.out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_bad", badCode, 0);
        checkOutput("abort_addr", outIf.out_addr, 0);
        checkOutput("abort_char", outIf.out_char_idx, 0);
        checkOutput("abort_row", outIf.out_row, 0);
        @(negedge clk);
        checkOutput("abort_no_done", done, 0);
        checkOutput("abort_idle_valid", outIf.out_valid, 0);
        return;
      end
      if (cycles > 20 * total + 100) begin
        checkOutput("beat_budget", beat, total);
        break;
      end
      checkOutput("valid", outIf.out_valid, 1);
      checkOutput("busy", busy, 1);
      checkOutput("done_early", done, 0);
      checkOutput("addr", outIf.out_addr, expA[beat]);
      checkOutput("char_idx", outIf.out_char_idx, expC[beat]);
      checkOutput("row", outIf.out_row, expR[beat]);

      outIf.out_ready = ($urandom_range(0, 99) >= stallPct);
      start    = ($urandom_range(0, 7) == 0);
      numChars = 4'($urandom_range(0, 15));
      wrEn     = ($urandom_range(0, 5) == 0);
      wrIdx    = 3'($urandom_range(0, MAXC - 1));
      wrChar   = 6'($urandom_range(0, 63));
      if (outIf.out_ready) begin
        obsAddr.push_back(int'(outIf.out_addr));
        beat++;
      end
      @(negedge clk);
      cycles++;
    end

    start = 1'b0;
    wrEn  = 1'b0;
    checkOutput("done_pulse", done, 1);
    checkOutput("done_valid", outIf.out_valid, 0);
    checkOutput("done_busy", busy, 0);
    checkOutput("bad_code", badCode, expBad);
    @(negedge clk);
    checkOutput("done_once", done, 0);
    checkOutput("idle_valid", outIf.out_valid, 0);
  endtask

  initial begin
    reset = 1'b1; wrEn = 1'b0; wrIdx = '0; wrChar = '0;
    numChars = '0; modeSel = 1'b0; start = 1'b0; outIf.out_ready = 1'b0;
    for (int i = 0; i < MAXC; i++) modelBuf[i] = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", outIf.out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_bad", badCode, 0);
    checkOutput("rst_addr", outIf.out_addr, 0);
    checkOutput("rst_char", outIf.out_char_idx, 0);
    checkOutput("rst_row", outIf.out_row, 0);
    reset = 1'b0;

    writeChar(0, 18); writeChar(1, 2); writeChar(2, 14); writeChar(3, 17); writeChar(4, 4);
    writeChar(5, 0);  writeChar(6, 0); writeChar(7, 0);

    applyStimulus(5, 1'b0, 0, -1, 1'b0);
    checkOutput("score_beats", obsAddr.size(), 40);
    checkOutput("score_b0", obsAddr[0], 12848);
    checkOutput("score_b1", obsAddr[1], 13008);
    checkOutput("score_b8", obsAddr[8], 10288);

    applyStimulus(5, 1'b1, 0, -1, 1'b0);
    checkOutput("rowmaj_b0", obsAddr[0], 12848);
    checkOutput("rowmaj_b1", obsAddr[1], 10288);
    checkOutput("rowmaj_b2", obsAddr[2], 11600);
    checkOutput("rowmaj_b3", obsAddr[3], 12840);
    checkOutput("rowmaj_b4", obsAddr[4], 10304);
    checkOutput("rowmaj_b5", obsAddr[5], 13008);

    applyStimulus(5, 1'b0, 40, -1, 1'b0);
    checkOutput("stall_beats", obsAddr.size(), 40);

    writeChar(0, 40);
    applyStimulus(1, 1'b0, 30, -1, 1'b0);
    for (int r = 0; r < GH; r++) checkOutput("badglyph_addr", obsAddr[r], 10272 + r * 160);
    repeat (3) @(negedge clk);
    checkOutput("bad_sticky", badCode, 1);

    applyStimulus(0, 1'b0, 0, -1, 1'b0);

    writeChar(0, 18);
    applyStimulus(15, 1'($urandom_range(0, 1)), 20, -1, 1'b0);
    checkOutput("clamp_beats", obsAddr.size(), 64);

    applyStimulus(5, 1'b0, 0, 10, 1'b0);
    applyStimulus(5, 1'b0, 0, -1, 1'b0);
    checkOutput("restart_b0", obsAddr[0], glyphAddr(modelBuf[0], 0));

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < MAXC; i++)
        writeChar(i, ($urandom_range(0, 9) == 0) ? $urandom_range(36, 63) : $urandom_range(0, 35));
      applyStimulus($urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 50),
                    -1, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
